key_event_encoder: RTL
======================

# key_event_encoder

Sits between `camera_ctrl` and `uart_ctrl`. Debounces the 40-bit `key_down` vector once per camera frame, detects press/release transitions, and queues one byte per transition in a small FIFO drained over a valid/ready handshake. The PC link therefore carries compact note events, not the raw 40-bit snapshot.

## Interface
- `NKEYS`, 40: number of keys; must be ≤ 64.
- `DEB_CNT`, 3: consecutive differing samples needed to change a key's stable state; range 1..7.
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of two.
- `clk  in  1`: system clock, drives all state.
- `rst  in  1`: reset, **synchronous, active-high**.
- `sample  in  1`: one-cycle pulse, once per camera frame; qualifies `key_down`.
- `key_down  in  NKEYS`: raw key vector from `camera_ctrl`.
- `ev_data  out  8`: event byte `{dir, 1'b0, idx[5:0]}`; dir=1 is press, dir=0 is release.
- `ev_valid  out  1`: FIFO non-empty.
- `ev_ready  in  1`: consumer accepts `ev_data` when `ev_valid & ev_ready`.
- `stable_keys  out  NKEYS`: debounced key state, for the UI.
- `busy  out  1`: high while a scan is in progress.
- `sample_drop  out  1`: sticky; set when a `sample` is lost. Cleared only by `rst`.
- `fifo_level  out  $clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- States: IDLE, SCAN.
- IDLE:
  - If `sample` or `pending` is set: copy `key_down` into `snap`, clear `pending`, set `idx`=0, go to SCAN.
- SCAN: handles one key per cycle, key `idx`.
  - raw=`snap[idx]`, st=`stable_keys[idx]`, cnt=`deb_cnt[idx]` (3 bits).
  - raw==st: cnt←0, advance.
  - raw≠st and cnt+1<DEB_CNT: cnt←cnt+1, advance.
  - raw≠st and cnt+1==DEB_CNT (commit): stable←raw, cnt←0, push `{raw,1'b0,idx}`, advance.
  - Commit while FIFO full with no pop this cycle: stall. `idx`, `stable_keys` and cnt hold; retry next cycle. Events are never lost.
  - Advance at `idx`==NKEYS-1 returns to IDLE.
- `sample` arriving in SCAN, or in the cycle IDLE is leaving: sets `pending`. If `pending` is already set, set `sample_drop` instead. `snap` is not overwritten mid-scan.
- FIFO:
  - Push is allowed when not full, or when full with a pop in the same cycle.
  - Pop occurs on `ev_valid & ev_ready`.
  - Output is first-word-fall-through: `ev_data` is valid whenever `ev_valid` is high and holds stable until popped.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally.
- Reset values:
  - State IDLE, `idx` 0, `pending` 0, `snap` 0.
  - All `deb_cnt` 0, `stable_keys` 0.
  - FIFO empty: `ev_valid` 0, `fifo_level` 0, `ev_data` 0.
  - `busy` 0, `sample_drop` 0.
- `rst` mid-scan: aborts the scan; queued events are discarded.

## Timing
- `sample` high in cycle t (IDLE): SCAN starts at cycle t+1 and handles key i in cycle t+1+i, absent stalls.
- Event for key i is written at the end of cycle t+1+i. If the FIFO was empty, `ev_valid` rises in cycle t+2+i.
- Scan length is NKEYS cycles plus stall cycles. `busy` is high for exactly those cycles.
- `stable_keys[i]` updates at the same edge as the push.
- Pop-to-next-word latency: 0 cycles. The next entry appears the cycle after the pop edge.
- A key press therefore needs DEB_CNT frames to register. With DEB_CNT=1, every change commits on the first differing sample.

## Structure
- Shared package `capiano_pkg`: `NKEYS`, event-byte field positions (`EV_DIR_BIT`=7, `EV_IDX_LSB`=0, `EV_IDX_W`=6), `DEB_CNT` default.
- One sub-module: `sync_fifo` (parameterised width and depth; push/pop/full/empty/level).
  - Reusable for the UART receive path.
- Scanner FSM and debounce counter array stay in `key_event_encoder`.

## Test plan
- **Debounce and encode.** Hold `key_down`=1<<5 for 3 samples, `ev_ready`=1.
  - Exactly one event 0x85 after the third scan.
  - `stable_keys[5]`=1.
- **Release.** From that state, hold `key_down`=0 for 3 samples.
  - One event 0x05.
  - No event after the 1st or 2nd sample.
- **Glitch rejection.** Toggle key 12 high for 2 samples, low for 1, high for 2.
  - No events.
  - `stable_keys[12]` stays 0.
- **FIFO full stall.** `ev_ready`=0, FIFO_DEPTH=8, commit presses on keys 0..9 in one scan.
  - `fifo_level` reaches 8; scan stalls at key 8 with `busy`=1.
  - After raising `ev_ready`, bytes 0x80..0x89 arrive in order with none missing.
- **Sample overrun.** Issue 3 `sample` pulses during one stalled scan.
  - `pending` serves the first; `sample_drop`=1 after the second extra pulse.
  - Exactly one further scan runs.
- **Reset mid-scan.** Assert `rst` for 1 cycle with 4 events queued.
  - Next cycle: `ev_valid`=0, `fifo_level`=0, `stable_keys`=0, `busy`=0, `sample_drop`=0.

Source files
------------

// File: rtl/capiano_pkg.sv
// Shared constants and helpers for the capiano key-scanning path.
// Event bytes are {dir, 1'b0, idx[5:0]}; dir=1 marks a press, dir=0 a release.
package capiano_pkg;

   localparam int NKEYS      = 40;
   localparam int DEB_CNT    = 3;
   localparam int FIFO_DEPTH = 8;

   localparam int EV_W       = 8;
   localparam int EV_DIR_BIT = 7;
   localparam int EV_IDX_LSB = 0;
   localparam int EV_IDX_W   = 6;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_e;

   function automatic logic [EV_W-1:0] make_event(input logic dir,
                                                  input logic [EV_IDX_W-1:0] idx);
      logic [EV_W-1:0] ev;
      ev = 8'h00;
      ev[EV_DIR_BIT] = dir;
      ev[EV_IDX_LSB +: EV_IDX_W] = idx;
      return ev;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   // Status flags and the fall-through read port.
   always_comb begin
      empty = (count_q == {(PTR_W+1){1'b0}});
      full  = (count_q == (PTR_W+1)'(DEPTH));
      level = count_q;
      if (empty) begin
         pop_data = {WIDTH{1'b0}};
      end else begin
         pop_data = mem_q[rd_ptr_q];
      end
   end

   // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
   always_comb begin
      do_pop_s  = pop & ~empty;
      do_push_s = push & (~full | do_pop_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {(PTR_W+1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/key_event_encoder.sv
// Debounces a frame-rate key snapshot one key per cycle and queues a byte per
// committed press/release into a FIFO drained over valid/ready.
module key_event_encoder #(
   parameter int NKEYS      = capiano_pkg::NKEYS,
   parameter int DEB_CNT    = capiano_pkg::DEB_CNT,
   parameter int FIFO_DEPTH = capiano_pkg::FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sample,
   input  logic [NKEYS-1:0]              key_down,
   output logic [7:0]                    ev_data,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [NKEYS-1:0]              stable_keys,
   output logic                          busy,
   output logic                          sample_drop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   import capiano_pkg::*;

   scan_state_e            state_q, state_d;
   logic [EV_IDX_W-1:0]    idx_q, idx_d;
   logic                   pending_q, pending_d;
   logic                   sample_drop_q, sample_drop_d;
   logic [NKEYS-1:0]       snap_q, snap_d;
   logic [NKEYS-1:0]       stable_q, stable_d;
   logic [2:0]             deb_cnt_q [NKEYS];
   logic [2:0]             deb_cnt_d [NKEYS];

   logic                   raw_s;
   logic                   st_s;
   logic [2:0]             cnt_s;
   logic [3:0]             cnt_inc_s;
   logic                   differ_s;
   logic                   scanning_s;
   logic                   commit_s;
   logic                   stall_s;
   logic                   advance_s;
   logic                   last_s;
   logic                   start_s;
   logic [EV_W-1:0]        ev_byte_s;
   logic                   fifo_full_s;
   logic                   fifo_empty_s;

   // Per-key debounce decision for the key under the scan pointer.
   always_comb begin
      scanning_s = (state_q == ST_SCAN);
      start_s    = (state_q == ST_IDLE) & (sample | pending_q);
      raw_s      = snap_q[idx_q];
      st_s       = stable_q[idx_q];
      cnt_s      = deb_cnt_q[idx_q];
      cnt_inc_s  = {1'b0, cnt_s} + 4'd1;
      differ_s   = raw_s ^ st_s;
      commit_s   = scanning_s & differ_s & (cnt_inc_s == 4'(DEB_CNT));
      // Full FIFO is never full-and-empty, so ev_ready alone tells whether a pop frees a slot.
      stall_s    = commit_s & fifo_full_s & ~ev_ready;
      advance_s  = scanning_s & ~stall_s;
      last_s     = (idx_q == EV_IDX_W'(NKEYS-1));
      ev_byte_s  = make_event(raw_s, idx_q);
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (advance_s && last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SCAN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      case (state_q)
         ST_SCAN: busy = 1'b1;
         ST_IDLE: busy = 1'b0;
         default: busy = 1'b0;
      endcase
      stable_keys = stable_q;
      sample_drop = sample_drop_q;
   end

   // Snapshot, pending/overrun tracking and debounce state updates.
   always_comb begin
      idx_d         = idx_q;
      pending_d     = pending_q;
      sample_drop_d = sample_drop_q;
      snap_d        = snap_q;
      stable_d      = stable_q;
      deb_cnt_d     = deb_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               snap_d    = key_down;
               idx_d     = {EV_IDX_W{1'b0}};
               // A sample landing while a pending scan launches becomes the next pending one.
               pending_d = pending_q & sample;
            end else begin
               pending_d = pending_q;
            end
         end
         ST_SCAN: begin
            if (sample) begin
               if (pending_q) begin
                  sample_drop_d = 1'b1;
               end else begin
                  pending_d = 1'b1;
               end
            end else begin
               pending_d = pending_q;
            end
            if (advance_s) begin
               if (last_s) begin
                  idx_d = {EV_IDX_W{1'b0}};
               end else begin
                  idx_d = idx_q + EV_IDX_W'(1);
               end
               if (commit_s) begin
                  stable_d[idx_q]  = raw_s;
                  deb_cnt_d[idx_q] = 3'd0;
               end else if (differ_s) begin
                  deb_cnt_d[idx_q] = cnt_inc_s[2:0];
               end else begin
                  deb_cnt_d[idx_q] = 3'd0;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            idx_d = {EV_IDX_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= {EV_IDX_W{1'b0}};
         pending_q     <= 1'b0;
         sample_drop_q <= 1'b0;
         snap_q        <= {NKEYS{1'b0}};
         stable_q      <= {NKEYS{1'b0}};
         for (int i = 0; i < NKEYS; i++) begin
            deb_cnt_q[i] <= 3'd0;
         end
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pending_q     <= pending_d;
         sample_drop_q <= sample_drop_d;
         snap_q        <= snap_d;
         stable_q      <= stable_d;
         deb_cnt_q     <= deb_cnt_d;
      end
   end

   sync_fifo #(
      .WIDTH (EV_W),
      .DEPTH (FIFO_DEPTH)
   ) u_event_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (commit_s),
      .push_data (ev_byte_s),
      .pop       (ev_ready),
      .pop_data  (ev_data),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (fifo_level)
   );

   assign ev_valid = ~fifo_empty_s;

endmodule
